// File: rtl/arm_mem_pkg.sv
// Shared definitions for the unified memory arbiter: FSM encoding, master
// indices and the wait-state counter width.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory array.
// Handshake: a master raises mN_req with stable we/adr/wdata and holds it
// until mN_ready pulses for exactly one cycle; mN_rdata is valid while
// mN_ready is high. Keeping req high past ready requests another access.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ready;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata,
    output m0_rdata, m0_ready,
    input  m1_req, m1_we, m1_adr, m1_wdata,
    output m1_rdata, m1_ready,
    output mem_en, mem_we, mem_adr, mem_wdata,
    input  mem_rdata
  );

  // Environment view (masters plus memory array).
  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata,
    input  m0_rdata, m0_ready,
    output m1_req, m1_we, m1_adr, m1_wdata,
    input  m1_rdata, m1_ready,
    input  mem_en, mem_we, mem_adr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// on a tie the master that was not granted last time wins.
module rr_arbiter2
  import arm_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       any
);

  // Winner selection.
  always_comb begin
    gnt = M_CORE;
    any = |req;
    case (req)
      2'b01:   gnt = M_CORE;
      2'b10:   gnt = M_DMA;
      2'b11:   gnt = ~last_gnt;
      default: gnt = M_CORE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter and access sequencer for the unified instruction/data
// memory. Master 0 is the core, master 1 the DMA/debug port. Each access
// spends WAIT_CYCLES+1 cycles in BUSY followed by one DONE cycle that pulses
// the granted master's ready. All outputs come from registered state only.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic       clk,
  input  logic       reset,
  mem_arbiter_if.slave bus,
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_q;
  logic             last_gnt_q;
  logic             we_q;
  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;

  logic             pick;
  logic             any_req;
  logic             busy;
  logic             final_busy;

  rr_arbiter2 u_rr (
    .req      ({bus.m1_req, bus.m0_req}),
    .last_gnt (last_gnt_q),
    .gnt      (pick),
    .any      (any_req)
  );

  assign busy       = (state_q == BUSY);
  assign final_busy = busy && (cnt_q == LAST_CNT);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant/attribute latches, wait counter and read-data capture. Requests
  // are only looked at in IDLE, so changes during BUSY are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      gnt_q      <= M_CORE;
      last_gnt_q <= M_DMA;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= pick;
            we_q    <= pick ? bus.m1_we    : bus.m0_we;
            adr_q   <= pick ? bus.m1_adr   : bus.m0_adr;
            wdata_q <= pick ? bus.m1_wdata : bus.m0_wdata;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (cnt_q == LAST_CNT) rdata_q <= bus.mem_rdata;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
        DONE: last_gnt_q <= gnt_q;
        default: ;
      endcase
    end
  end

  // Memory side: address/data only driven while an access is active so
  // they read as zero in reset and idle.
  assign bus.mem_en    = busy;
  assign bus.mem_we    = final_busy && we_q;
  assign bus.mem_adr   = busy ? adr_q   : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;

  // Master side: one-cycle ready to the granted master; both read ports
  // show the most recently captured word.
  assign bus.m0_ready = (state_q == DONE) && (gnt_q == M_CORE);
  assign bus.m1_ready = (state_q == DONE) && (gnt_q == M_DMA);
  assign bus.m0_rdata = rdata_q;
  assign bus.m1_rdata = rdata_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A with two wait states backed by
// a small memory model, instance B with zero wait states backed by an
// address-derived read pattern.
module tb_mem_arbiter;
  import arm_mem_pkg::*;

  localparam int WA = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  logic tb_load;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) ifa ();
  mem_arbiter_if #(.AW(32), .DW(32)) ifb ();
  state_t dbg_a;
  state_t dbg_b;

  mem_arbiter #(.WAIT_CYCLES(WA), .AW(32), .DW(32)) u_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifa),
    .dbg_state (dbg_a)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .AW(32), .DW(32)) u_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifb),
    .dbg_state (dbg_b)
  );

  // Memory for instance A: 64 words, combinational read, write on mem_we.
  logic [31:0] mem_a [0:63];
  assign ifa.mem_rdata = mem_a[ifa.mem_adr[7:2]];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 32'h0;
      mem_a[24] <= 32'h0000_0007;   // 0x60
      mem_a[25] <= 32'hdead_beef;   // 0x64
      mem_a[26] <= 32'h0000_1234;   // 0x68
      mem_a[27] <= 32'ha5a5_a5a5;   // 0x6c
    end else if (ifa.mem_we) begin
      mem_a[ifa.mem_adr[7:2]] <= ifa.mem_wdata;
    end
  end

  // Instance B memory: read data derived from the address.
  assign ifb.mem_rdata = {ifb.mem_adr[15:0], 16'hbeef};

  // Scoreboard: {check_data, master, rdata}.
  logic [33:0] exp_q[$];
  logic [33:0] exp_e;
  logic        prev_rdy;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void check(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Ready monitor for instance A: pops one expectation per ready pulse.
  initial prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (ifa.m0_ready || ifa.m1_ready) begin
      check("rdy_onehot", ifa.m0_ready & ifa.m1_ready, 0);
      check("rdy_1cycle", prev_rdy, 0);
      check("rdy_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("rdy_master", ifa.m1_ready, exp_e[32]);
        if (exp_e[33])
          check("rdy_rdata", ifa.m1_ready ? ifa.m1_rdata : ifa.m0_rdata, exp_e[31:0]);
      end
    end
    prev_rdy = ifa.m0_ready | ifa.m1_ready;
  end

  // Driver tasks.
  task automatic drive_req(input logic m, input logic v, input logic we,
                           input logic [31:0] adr, input logic [31:0] wdata);
    if (m) begin
      ifa.m1_req = v; ifa.m1_we = we; ifa.m1_adr = adr; ifa.m1_wdata = wdata;
    end else begin
      ifa.m0_req = v; ifa.m0_we = we; ifa.m0_adr = adr; ifa.m0_wdata = wdata;
    end
  endtask

  // One complete access on instance A starting from an IDLE cycle.
  task automatic run_access(input logic m, input logic we, input logic [31:0] adr,
                            input logic [31:0] wdata, input logic chk,
                            input logic [31:0] exp_rd);
    check("acc_idle_en", ifa.mem_en, 0);
    drive_req(m, 1'b1, we, adr, wdata);
    exp_q.push_back({chk, m, exp_rd});
    for (int k = 1; k <= WA + 1; k++) begin
      @(negedge clk);
      check("busy_en", ifa.mem_en, 1);
      check("busy_adr", ifa.mem_adr, adr);
      check("busy_wdata", ifa.mem_wdata, wdata);
      check("busy_we", ifa.mem_we, (we && k == WA + 1));
      check("busy_rdy", ifa.m0_ready | ifa.m1_ready, 0);
    end
    @(negedge clk);
    check("done_en", ifa.mem_en, 0);
    check("done_we", ifa.mem_we, 0);
    check("done_rdy0", ifa.m0_ready, !m);
    check("done_rdy1", ifa.m1_ready, m);
    drive_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_rdy", ifa.m0_ready | ifa.m1_ready, 0);
  endtask

  int          n_rdy;
  logic [31:0] rnd;

  initial begin
    reset = 1'b1;
    tb_load = 1'b1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h68, 32'h0);
    ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_adr = '0; ifb.m0_wdata = '0;
    ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_adr = '0; ifb.m1_wdata = '0;

    // Reset held 3 cycles with both requests high: everything stays zero.
    repeat (3) begin
      @(negedge clk);
      check("rst_en", ifa.mem_en, 0);
      check("rst_we", ifa.mem_we, 0);
      check("rst_adr", ifa.mem_adr, 0);
      check("rst_wdata", ifa.mem_wdata, 0);
      check("rst_rdy0", ifa.m0_ready, 0);
      check("rst_rdy1", ifa.m1_ready, 0);
      check("rst_rd0", ifa.m0_rdata, 0);
      check("rst_rd1", ifa.m1_rdata, 0);
      check("rst_state", dbg_a, IDLE);
    end
    reset = 1'b0;
    tb_load = 1'b0;

    // Round robin with both requests held: m0, m1, m0, m1.
    exp_q.push_back({1'b1, 1'b0, 32'h0000_0007});
    exp_q.push_back({1'b1, 1'b1, 32'h0000_1234});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_0007});
    exp_q.push_back({1'b1, 1'b1, 32'h0000_1234});
    @(negedge clk);
    check("first_en", ifa.mem_en, 1);
    check("first_adr", ifa.mem_adr, 32'h60);
    n_rdy = 0;
    for (int c = 0; c < 40 && n_rdy < 4; c++) begin
      @(negedge clk);
      if (ifa.m0_ready || ifa.m1_ready) n_rdy++;
      if (n_rdy == 4) begin
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check("rr_count", n_rdy, 4);
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rr_q_empty", exp_q.size(), 0);

    // m0 read of 0x60, m1 write 7 to 0x64, m0 re-read of 0x64.
    run_access(1'b0, 1'b0, 32'h60, 32'h0, 1'b1, 32'h7);
    run_access(1'b1, 1'b1, 32'h64, 32'h7, 1'b0, 32'h0);
    run_access(1'b0, 1'b0, 32'h64, 32'h0, 1'b1, 32'h7);

    // Random write by one master, read back by the other.
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom_range(32'hffff_fffe, 1);
      run_access(1'(i % 2), 1'b1, 32'h80 + 32'(4 * i), rnd, 1'b0, 32'h0);
      run_access(1'(~(i % 2)), 1'b0, 32'h80 + 32'(4 * i), 32'h0, 1'b1, rnd);
    end

    // Reset in the second BUSY cycle of an m0 write drops the access.
    drive_req(1'b0, 1'b1, 1'b1, 32'h6c, 32'h55);
    @(negedge clk);
    check("abort_b1_en", ifa.mem_en, 1);
    check("abort_b1_we", ifa.mem_we, 0);
    @(negedge clk);
    check("abort_b2_en", ifa.mem_en, 1);
    check("abort_b2_we", ifa.mem_we, 0);
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("abort_en", ifa.mem_en, 0);
    check("abort_we", ifa.mem_we, 0);
    check("abort_rdy0", ifa.m0_ready, 0);
    check("abort_state", dbg_a, IDLE);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_idle_en", ifa.mem_en, 0);
      check("abort_idle_we", ifa.mem_we, 0);
    end
    // Location untouched, and a fresh request completes normally.
    run_access(1'b0, 1'b0, 32'h6c, 32'h0, 1'b1, 32'ha5a5_a5a5);

    // Zero wait states: one BUSY cycle, ready two cycles after the request.
    ifb.m0_req = 1'b1;
    ifb.m0_adr = 32'h60;
    @(negedge clk);
    check("w0_en", ifb.mem_en, 1);
    check("w0_adr", ifb.mem_adr, 32'h60);
    check("w0_busy_rdy", ifb.m0_ready, 0);
    @(negedge clk);
    check("w0_done_en", ifb.mem_en, 0);
    check("w0_rdy0", ifb.m0_ready, 1);
    check("w0_rdy1", ifb.m1_ready, 0);
    check("w0_rdata", ifb.m0_rdata, 32'h0060_beef);
    ifb.m0_req = 1'b0;
    @(negedge clk);
    check("w0_post_rdy", ifb.m0_ready, 0);
    check("w0_post_en", ifb.mem_en, 0);

    repeat (2) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and access sequencer for the single unified instruction/data memory of the multicycle ARM system. It shares the memory between the `arm_multi` core (master 0) and a DMA/debug port (master 1). It inserts a fixed number of memory wait states and returns completion via a one-cycle ready pulse per master. It sits between the masters and the memory array and drives all memory address, data and enable lines.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: extra memory cycles per access. Legal range 0..15.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req`  in  1  core access request; held until `m0_ready`
- `m0_we`  in  1  core write (1) / read (0)
- `m0_adr`  in  AW  core address
- `m0_wdata`  in  DW  core write data
- `m0_rdata`  out  DW  core read data; valid while `m0_ready`=1
- `m0_ready`  out  1  core completion pulse, 1 cycle
- `m1_req`, `m1_we`, `m1_adr`, `m1_wdata`, `m1_rdata`, `m1_ready`: same as m0, for the DMA port
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write strobe
- `mem_adr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data; combinational from `mem_adr`

## Operation
- FSM states:
  - IDLE: no access in progress; arbitrate among pending requests.
  - BUSY: access in progress; counter runs 0..WAIT_CYCLES.
  - DONE: ready pulse to the granted master.
- IDLE, no requests: stay in IDLE.
- IDLE, request(s) pending: choose a winner, then go to BUSY. On entry, latch:
  - `gnt` (winner index)
  - we, adr and wdata from the winner
  - clear the counter
- Arbitration is round-robin. A single requester always wins. With both requesting, the master not granted last wins. `last_gnt` resets to 1, so m0 wins the first tie.
- BUSY:
  - `mem_en`=1; `mem_adr` and `mem_wdata` come from the latched copies.
  - `mem_we`=1 only in the final BUSY cycle (counter==WAIT_CYCLES) and only for writes.
  - At the final edge, capture `mem_rdata` into the read-data register and go to DONE.
- DONE:
  - `mN_ready`=1 for the granted master only; `mN_rdata` holds the captured word (writes return the last captured value).
  - Update `last_gnt` ← `gnt`, then go to IDLE unconditionally.
- A master may keep `req` high after ready to issue a back-to-back request. The arbiter samples it in the following IDLE cycle.
- `req` or its attributes changing during BUSY is a protocol violation. The arbiter ignores the change, completes the latched access, and still pulses ready.
- Address bits pass through unmodified; alignment is the master's responsibility.
- Reset, including mid-access: state=IDLE, counter=0, `last_gnt`=1. The abandoned access is dropped: no ready pulse and no further `mem_we`.

## Timing
- Every output is registered or decoded from registered state only. No combinational path from `req` to any output.
- Reset values of all outputs are 0: `mem_en`, `mem_we`, `mem_adr`, `mem_wdata`, both `mN_ready`, both `mN_rdata`.
- Request sampled high in IDLE at cycle t:
  - BUSY occupies cycles t+1..t+1+WAIT_CYCLES.
  - ready is high in cycle t+2+WAIT_CYCLES.
- Write strobe is in cycle t+1+WAIT_CYCLES.
- Maximum throughput is one access per WAIT_CYCLES+3 cycles.
- Worst-case wait for a losing master is one full access (WAIT_CYCLES+3 cycles), then its own access.

## Structure
- Shared package `arm_mem_pkg` holds:
  - state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - master index constants `M_CORE`=0, `M_DMA`=1
  - counter width constant (4)
- Sub-module `rr_arbiter2`: combinational 2-way round-robin picker. Inputs `req[1:0]`, `last_gnt`; outputs `gnt`, `any`. The FSM, counter and latches stay in `mem_arbiter`.

## Test plan
- Reset held 3 cycles with both req=1 → all outputs 0 throughout; first `mem_en` appears in the cycle after reset deasserts +1.
- WAIT_CYCLES=2; m0 reads `adr`=0x60, memory holds 7 at 0x60 → `mem_en` high for cycles 1..3, `m0_ready`=1 in cycle 4 with `m0_rdata`=7, `m1_ready`=0.
- m1 writes 7 to 0x64 → exactly one `mem_we` cycle with `mem_adr`=0x64 and `mem_wdata`=7; `m1_ready` pulses next cycle; a re-read by m0 returns 7.
- Both req held high from reset release → grant order m0, m1, m0, m1; each ready pulse is exactly 1 cycle and goes to the correct master only.
- Reset asserted in the second BUSY cycle of an m0 write → `mem_en`=0 next cycle, no `mem_we`, no `m0_ready`; a new m0 request afterwards completes normally.
- WAIT_CYCLES=0 instance; m0 read → `mem_en` for 1 cycle, `m0_ready` 2 cycles after the request cycle.
